pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Program-counter generator for the fetch stage of the 5-stage pipeline.
- Directly upstream of the IF/ID PC buffer: its pc_out feeds that buffer's pc_out input every cycle.
- Owns the fetch PC register, the sequential +4 increment, the load-use stall hold, and redirects from branch/jump, trap and mret.
- Drives a flush strobe that kills the wrong-path instruction entering IF/ID.

Parameters:
- RESET_VECTOR, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- PC_INC, 4: sequential increment in bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_if  in  1  hazard unit request to hold the current PC.
- br_taken  in  1  execute stage resolved a taken branch or jump.
- br_target  in  32  branch/jump target address.
- trap_req  in  1  CSR unit requests trap entry.
- trap_vec  in  32  trap handler address (mtvec).
- mret_req  in  1  CSR unit requests return from trap.
- epc  in  32  return address (mepc).
- pc_out  out  32  current fetch PC, to instruction memory and the IF/ID PC buffer.
- pc_valid  out  1  pc_out is a real fetch address.
- flush_if  out  1  combinational; kill the instruction entering IF/ID at this edge.
- misalign  out  1  registered; selected redirect target had nonzero bits [1:0].
- redirect_cnt  out  32  redirect counter (see Optional Feature).

Behaviour:
- One clock, clk. rst is sampled only at the rising edge of clk; it has top priority and applies from any state.
- Reset values: pc_out=RESET_VECTOR, pc_valid=0, misalign=0, redirect_cnt=0, state=BOOT.
- flush_if is 0 whenever state is BOOT.
- States:
  - BOOT: pc_valid=0; all request inputs ignored; next edge goes to RUN with pc_out unchanged (first fetch = RESET_VECTOR).
  - RUN: pc_valid=1; normal operation.
  - REDIR: pc_valid=1; lasts exactly one cycle after an accepted redirect; next state RUN unless a new redirect is accepted.
- Next-PC priority, RUN and REDIR, per edge:
  1. trap_req: load trap_vec.
  2. mret_req: load epc.
  3. br_taken: load br_target; honoured in RUN only, ignored in REDIR because it comes from a squashed slot.
  4. stall_if: hold pc_out.
  5. Otherwise: pc_out + PC_INC.
- Accepted redirect:
  - The loaded value is target with bits [1:0] forced to 00.
  - misalign is 1 for the following cycle if the raw target had nonzero bits [1:0], else 0.
  - State moves to REDIR.
- A redirect overrides stall_if in the same cycle; the stall is dropped.
- flush_if = (state!=BOOT) and (any redirect accepted this cycle). It is combinational so the IF/ID buffer clears at the same edge the PC changes.
- Latency: a redirect request in cycle N gives pc_out=target in cycle N+1.
- Wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- stall_if held for multiple cycles holds pc_out indefinitely; pc_valid stays 1.
- Reset mid-operation or mid-redirect:
  - State goes to BOOT; the pending target is discarded.
  - flush_if is 0 in the cycle rst is asserted.
  - redirect_cnt is cleared.

Optional Feature:
- Macro: PC_GEN_REDIRECT_CNT_EN.
- Defined:
  - redirect_cnt increments by 1 at each accepted redirect (trap, mret, or honoured branch).
  - It saturates at 32'hFFFF_FFFF.
  - It is cleared by rst.
- Undefined:
  - No counter register is built.
  - redirect_cnt is tied to 32'h0.

Test Plan:
- Reset then run: assert rst 2 cycles, release, no requests.
  - Required: pc_valid=0 in BOOT, then pc_out = 0, 4, 8, 12 with pc_valid=1.
- Stall versus branch: stall_if high 3 cycles at pc_out=0x10 -> pc_out holds 0x10, then 0x14. Then br_taken with br_target=0x100 while stall_if=1 -> flush_if=1 that cycle, pc_out=0x100 next cycle, stall ignored.
- Simultaneous requests: trap_req, mret_req and br_taken in one cycle, trap_vec=0x200, epc=0x300, br_target=0x400 -> pc_out=0x200.
- Squashed-slot branch: br_taken in REDIR -> ignored, pc_out advances by +4. mret_req in REDIR with epc=0x84 -> pc_out=0x84.
- Misaligned target and wrap: br_target=0x102 -> pc_out=0x100, misalign=1 for one cycle. PC at 0xFFFF_FFFC with no requests -> 0x0.
- Reset and counter:
  - rst asserted in the cycle after a redirect -> pc_out=RESET_VECTOR, BOOT, flush_if=0.
  - With PC_GEN_REDIRECT_CNT_EN: 3 redirects -> redirect_cnt=3, then 0 after rst.
  - Without the macro: redirect_cnt stays 0 throughout.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with stall hold, trap/mret/branch redirect and IF/ID flush strobe.
// Defining PC_GEN_REDIRECT_CNT_EN builds a saturating counter of accepted redirects.
module pc_gen #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] PC_INC       = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_if,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        trap_req,
   input  logic [31:0] trap_vec,
   input  logic        mret_req,
   input  logic [31:0] epc,
   output logic [31:0] pc_out,
   output logic        pc_valid,
   output logic        flush_if,
   output logic        misalign,
   output logic [31:0] redirect_cnt
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      REDIR = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_target;
   logic        w_redirect;
   logic        r_misalign;
   logic        w_misalign_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= BOOT;
         r_pc       <= RESET_VECTOR;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_misalign <= w_misalign_nxt;
      end
   end

   // Branches seen in REDIR come from the squashed slot, so only RUN honours them.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_target    = 32'h0;
      w_redirect  = 1'b0;
      case (r_state)
         BOOT: w_state_nxt = RUN;
         RUN, REDIR: begin
            if (trap_req) begin
               w_redirect = 1'b1;
               w_target   = trap_vec;
            end else if (mret_req) begin
               w_redirect = 1'b1;
               w_target   = epc;
            end else if (br_taken && (r_state == RUN)) begin
               w_redirect = 1'b1;
               w_target   = br_target;
            end
            if (w_redirect) begin
               w_pc_nxt    = {w_target[31:2], 2'b00};
               w_state_nxt = REDIR;
            end else begin
               w_state_nxt = RUN;
               if (!stall_if) begin
                  w_pc_nxt = r_pc + PC_INC;
               end
            end
         end
         default: w_state_nxt = BOOT;
      endcase
      w_misalign_nxt = w_redirect && (w_target[1:0] != 2'b00);
   end

   assign pc_out   = r_pc;
   assign pc_valid = (r_state != BOOT);
   assign misalign = r_misalign;
   // Combinational so IF/ID clears on the same edge the PC jumps; a reset edge never flushes.
   assign flush_if = w_redirect && !rst;

`ifdef PC_GEN_REDIRECT_CNT_EN
   logic [31:0] r_redirect_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_redirect_cnt <= 32'h0;
      end else if (w_redirect && (r_redirect_cnt != 32'hFFFF_FFFF)) begin
         r_redirect_cnt <= r_redirect_cnt + 32'd1;
      end
   end

   assign redirect_cnt = r_redirect_cnt;
`else
   assign redirect_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and randomized checks of pc_gen against a cycle-level behavioural model.
// The counter expectations follow PC_GEN_REDIRECT_CNT_EN as seen by this bench.
module tb_pc_gen;

   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst, stall_if, br_taken, trap_req, mret_req;
   logic [31:0] br_target, trap_vec, epc;
   logic [31:0] pc_out, redirect_cnt;
   logic        pc_valid, flush_if, misalign;

   int n_pass  = 0;
   int n_total = 0;

   // Model: current and next-cycle architectural view.
   logic [31:0] m_pc = RV, x_pc = RV;
   logic [31:0] m_cnt = 0, x_cnt = 0;
   bit          m_boot = 1, x_boot = 1;
   bit          m_after_redir = 0, x_after_redir = 0;
   bit          m_mis = 0, x_mis = 0;
   bit          e_flush = 0;

   pc_gen #(.RESET_VECTOR(RV), .PC_INC(32'd4)) dut (
      .clk(clk), .rst(rst), .stall_if(stall_if),
      .br_taken(br_taken), .br_target(br_target),
      .trap_req(trap_req), .trap_vec(trap_vec),
      .mret_req(mret_req), .epc(epc),
      .pc_out(pc_out), .pc_valid(pc_valid), .flush_if(flush_if),
      .misalign(misalign), .redirect_cnt(redirect_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_cnt();
`ifdef PC_GEN_REDIRECT_CNT_EN
      return m_cnt;
`else
      return 32'h0;
`endif
   endfunction

   // Applies inputs for the coming edge and works out what the model expects.
   task automatic drive(input bit r, input bit s, input bit b, input logic [31:0] bt,
                        input bit t, input logic [31:0] tv, input bit m, input logic [31:0] ep);
      logic [31:0] tgt;
      bit          take;
      rst = r; stall_if = s; br_taken = b; br_target = bt;
      trap_req = t; trap_vec = tv; mret_req = m; epc = ep;
      x_cnt = m_cnt;
      if (r) begin
         x_pc = RV; x_boot = 1; x_after_redir = 0; x_mis = 0; x_cnt = 0; e_flush = 0;
      end else if (m_boot) begin
         x_pc = m_pc; x_boot = 0; x_after_redir = 0; x_mis = 0; e_flush = 0;
      end else begin
         take = t || m || (b && !m_after_redir);
         tgt  = t ? tv : (m ? ep : bt);
         x_boot = 0;
         if (take) begin
            x_pc = (tgt / 4) * 4;
            x_mis = (tgt % 4) != 0;
            x_after_redir = 1;
            if (m_cnt != 32'hFFFF_FFFF) x_cnt = m_cnt + 1;
            e_flush = 1;
         end else begin
            x_pc = s ? m_pc : m_pc + 32'd4;
            x_mis = 0; x_after_redir = 0; e_flush = 0;
         end
      end
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      m_pc = x_pc; m_boot = x_boot; m_after_redir = x_after_redir; m_mis = x_mis; m_cnt = x_cnt;
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      n_total++;
      if (flush_if !== 1'b0) $display("FAIL reset_flush: flush_if=%b want 0", flush_if);
      else n_pass++;
      tick();
      tick();
      n_total++;
      if ({pc_out, pc_valid, misalign, redirect_cnt} !== {RV, 1'b0, 1'b0, 32'h0})
         $display("FAIL reset_state: pc=%h vld=%b mis=%b cnt=%0d want pc=%h vld=0 mis=0 cnt=0",
                  pc_out, pc_valid, misalign, redirect_cnt, RV);
      else n_pass++;
      drive(0, 0, 1, 32'h80, 1, 32'h90, 1, 32'hA0);
      n_total++;
      if ({flush_if, pc_valid} !== 2'b00)
         $display("FAIL boot_ignore: flush=%b vld=%b want 0 0", flush_if, pc_valid);
      else n_pass++;
      tick();
   endtask

   task automatic test_run();
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if ({pc_out, pc_valid} !== {i[29:0], 2'b00, 1'b1})
            $display("FAIL run_seq%0d: pc=%h vld=%b want pc=%h vld=1", i, pc_out, pc_valid, i * 4);
         else n_pass++;
         idle();
         tick();
      end
   endtask

   task automatic test_stall_branch();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0, 0, 0, 0, 0);
         tick();
         n_total++;
         if ({pc_out, pc_valid} !== {32'h10, 1'b1})
            $display("FAIL stall_hold%0d: pc=%h vld=%b want 00000010 1", i, pc_out, pc_valid);
         else n_pass++;
      end
      idle();
      tick();
      n_total++;
      if (pc_out !== 32'h14) $display("FAIL stall_release: pc=%h want 00000014", pc_out);
      else n_pass++;
      drive(0, 1, 1, 32'h100, 0, 0, 0, 0);
      n_total++;
      if (flush_if !== 1'b1) $display("FAIL br_flush: flush_if=%b want 1", flush_if);
      else n_pass++;
      tick();
      n_total++;
      if (pc_out !== 32'h100) $display("FAIL br_over_stall: pc=%h want 00000100", pc_out);
      else n_pass++;
      idle();
      tick();
   endtask

   task automatic test_simultaneous();
      drive(0, 0, 1, 32'h400, 1, 32'h200, 1, 32'h300);
      tick();
      n_total++;
      if (pc_out !== 32'h200) $display("FAIL priority: pc=%h want 00000200", pc_out);
      else n_pass++;
   endtask

   task automatic test_squash();
      drive(0, 0, 1, 32'h500, 0, 0, 0, 0);
      n_total++;
      if (flush_if !== 1'b0) $display("FAIL squash_flush: flush_if=%b want 0", flush_if);
      else n_pass++;
      tick();
      n_total++;
      if (pc_out !== 32'h204) $display("FAIL squash_br: pc=%h want 00000204", pc_out);
      else n_pass++;
      drive(0, 0, 0, 0, 1, 32'h80, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 1, 32'h84);
      n_total++;
      if (flush_if !== 1'b1) $display("FAIL redir_mret_flush: flush_if=%b want 1", flush_if);
      else n_pass++;
      tick();
      n_total++;
      if (pc_out !== 32'h84) $display("FAIL redir_mret: pc=%h want 00000084", pc_out);
      else n_pass++;
      idle();
      tick();
   endtask

   task automatic test_misalign_wrap();
      drive(0, 0, 1, 32'h102, 0, 0, 0, 0);
      tick();
      n_total++;
      if ({pc_out, misalign} !== {32'h100, 1'b1})
         $display("FAIL misalign_set: pc=%h mis=%b want 00000100 1", pc_out, misalign);
      else n_pass++;
      idle();
      tick();
      n_total++;
      if ({pc_out, misalign} !== {32'h104, 1'b0})
         $display("FAIL misalign_clear: pc=%h mis=%b want 00000104 0", pc_out, misalign);
      else n_pass++;
      drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
      tick();
      idle();
      tick();
      n_total++;
      if ({pc_out, pc_valid, misalign} !== {32'h0, 1'b1, 1'b0})
         $display("FAIL wrap: pc=%h vld=%b mis=%b want 00000000 1 0", pc_out, pc_valid, misalign);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      drive(0, 0, 1, 32'h40, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 1, 32'h300, 0, 0);
      n_total++;
      if (flush_if !== 1'b0) $display("FAIL rst_mid_flush: flush_if=%b want 0", flush_if);
      else n_pass++;
      tick();
      n_total++;
      if ({pc_out, pc_valid, redirect_cnt} !== {RV, 1'b0, 32'h0})
         $display("FAIL rst_mid_state: pc=%h vld=%b cnt=%0d want %h 0 0", pc_out, pc_valid, redirect_cnt, RV);
      else n_pass++;
      drive(0, 0, 0, 0, 1, 32'h300, 0, 0);
      tick();
      n_total++;
      if ({pc_out, pc_valid} !== {RV, 1'b1})
         $display("FAIL boot_to_run: pc=%h vld=%b want %h 1", pc_out, pc_valid, RV);
      else n_pass++;
   endtask

   task automatic test_counter();
      logic [31:0] want;
`ifdef PC_GEN_REDIRECT_CNT_EN
      want = 32'd3;
`else
      want = 32'd0;
`endif
      drive(0, 0, 0, 0, 1, 32'h10, 0, 0); tick();
      idle(); tick();
      drive(0, 0, 0, 0, 0, 0, 1, 32'h20); tick();
      idle(); tick();
      drive(0, 0, 1, 32'h30, 0, 0, 0, 0); tick();
      n_total++;
      if (redirect_cnt !== want) $display("FAIL cnt_three: cnt=%0d want %0d", redirect_cnt, want);
      else n_pass++;
      drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
      n_total++;
      if (redirect_cnt !== 32'h0) $display("FAIL cnt_rst: cnt=%0d want 0", redirect_cnt);
      else n_pass++;
      idle(); tick();
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 5) == 0), $urandom(),
               ($urandom_range(0, 11) == 0), $urandom(),
               ($urandom_range(0, 9) == 0), $urandom());
         n_total++;
         if (flush_if !== e_flush) begin
            if (errs < 10) $display("FAIL rand_flush%0d: flush_if=%b want %b", i, flush_if, e_flush);
            errs++;
         end else n_pass++;
         tick();
         n_total++;
         if ({pc_out, pc_valid, misalign, redirect_cnt} !== {m_pc, !m_boot, m_mis, exp_cnt()}) begin
            if (errs < 10)
               $display("FAIL rand_state%0d: pc=%h vld=%b mis=%b cnt=%0d want pc=%h vld=%b mis=%b cnt=%0d",
                        i, pc_out, pc_valid, misalign, redirect_cnt, m_pc, !m_boot, m_mis, exp_cnt());
            errs++;
         end else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_run();
      test_stall_branch();
      test_simultaneous();
      test_squash();
      test_misalign_wrap();
      test_reset_mid();
      test_counter();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
